// File: rtl/ram_sync_pkg.sv
// Shared constants, FSM state type and sizing helper for the ram_sync_dp_be family.
package ram_sync_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int calc_nbytes(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/ram_byte_parity.sv
// Per-byte even parity generator/checker; err_o flags any byte whose recomputed
// parity disagrees with par_i.
module ram_byte_parity #(
    parameter int NBYTES = 4
) (
    input  logic [8*NBYTES-1:0] data_i,
    input  logic [NBYTES-1:0]   par_i,
    output logic [NBYTES-1:0]   par_o,
    output logic                err_o
);

    always_comb begin
        par_o = '0;
        for (int i = 0; i < NBYTES; i++) begin
            par_o[i] = ^data_i[8*i +: 8];
        end
    end

    assign err_o = |(par_o ^ par_i);

endmodule

// File: rtl/ram_sync_dp_be.sv
// Simple dual-port sync RAM with byte enables, 1/2-cycle read latency and post-reset zero clear.
// Defining RAM_SYNC_DP_PARITY_EN adds one stored even-parity bit per byte and drives rd_perr_o.
//
// state | meaning
// CLEAR | writes zero to row clr_cnt_q each cycle; requests ignored, ready_o = 0
// RUN   | normal read/write service until reset
module ram_sync_dp_be
    import ram_sync_pkg::*;
#(
    parameter int  AWIDTH       = 3,
    parameter int  DWIDTH       = 32,
    parameter int  READ_LATENCY = 1,
    parameter int  RDW_MODE     = RDW_OLD,
    localparam int DEPTH        = 1 << AWIDTH,
    localparam int NBYTES       = calc_nbytes(DWIDTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic [NBYTES-1:0] wr_be_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_perr_o,
    output logic              ready_o,
    output logic              init_busy_o
);

`ifdef RAM_SYNC_DP_PARITY_EN
    localparam int MW = DWIDTH + NBYTES;
`else
    localparam int MW = DWIDTH;
`endif

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [MW-1:0]     mem_q [DEPTH];

    logic              wr_acc, rd_acc, mem_we, rd_err;
    logic [AWIDTH-1:0] mem_waddr;
    logic [MW-1:0]     mem_wrow, wr_row, rd_row;

`ifdef RAM_SYNC_DP_PARITY_EN
    logic [NBYTES-1:0] wr_par, rd_par_calc;
    logic              wr_par_err;

    ram_byte_parity #(.NBYTES(NBYTES)) u_wr_par (
        .data_i (wr_data_i),
        .par_i  ({NBYTES{1'b0}}),
        .par_o  (wr_par),
        .err_o  (wr_par_err)
    );

    ram_byte_parity #(.NBYTES(NBYTES)) u_rd_par (
        .data_i (rd_row[DWIDTH-1:0]),
        .par_i  (rd_row[MW-1:DWIDTH]),
        .par_o  (rd_par_calc),
        .err_o  (rd_err)
    );
`else
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AWIDTH'(DEPTH - 1)) state_d = RUN;
            end
            RUN:   state_d = RUN;
        endcase
    end

    assign ready_o     = (state_q == RUN);
    assign init_busy_o = (state_q == CLEAR);
    assign wr_acc      = wr_en_i & ready_o;
    assign rd_acc      = rd_en_i & ready_o;

    // Full merged row for the write address; also serves as the "new data" view on a collision.
    always_comb begin
        wr_row = mem_q[wr_addr_i];
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_be_i[i]) begin
                wr_row[8*i +: 8] = wr_data_i[8*i +: 8];
`ifdef RAM_SYNC_DP_PARITY_EN
                wr_row[DWIDTH+i] = wr_par[i];
`endif
            end
        end
    end

    assign mem_we    = init_busy_o | wr_acc;
    assign mem_waddr = init_busy_o ? clr_cnt_q : wr_addr_i;
    assign mem_wrow  = init_busy_o ? '0 : wr_row;

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wrow;
    end

    assign rd_row = (RDW_MODE == RDW_NEW && wr_acc && wr_addr_i == rd_addr_i) ?
                    wr_row : mem_q[rd_addr_i];

    logic              rd1_valid_q, rd1_perr_q;
    logic [DWIDTH-1:0] rd1_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
            rd1_perr_q  <= 1'b0;
        end else begin
            rd1_valid_q <= rd_acc;
            if (rd_acc) begin
                rd1_data_q <= rd_row[DWIDTH-1:0];
                rd1_perr_q <= rd_err;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              rd2_valid_q, rd2_perr_q;
            logic [DWIDTH-1:0] rd2_data_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd2_valid_q <= 1'b0;
                    rd2_data_q  <= '0;
                    rd2_perr_q  <= 1'b0;
                end else begin
                    rd2_valid_q <= rd1_valid_q;
                    if (rd1_valid_q) begin
                        rd2_data_q <= rd1_data_q;
                        rd2_perr_q <= rd1_perr_q;
                    end
                end
            end

            assign rd_valid_o = rd2_valid_q;
            assign rd_data_o  = rd2_data_q;
            assign rd_perr_o  = rd2_valid_q & rd2_perr_q;
        end else begin : g_lat1
            assign rd_valid_o = rd1_valid_q;
            assign rd_data_o  = rd1_data_q;
            assign rd_perr_o  = rd1_valid_q & rd1_perr_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sync_dp_be.sv
// Bench for ram_sync_dp_be: two instances (latency 1 / old-data, latency 2 / new-data) share one
// stimulus stream and are checked every cycle against an array-based model plus literal vectors.
`timescale 1ns/1ps
module tb_ram_sync_dp_be;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 8;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be   = '0;

    logic [DW-1:0] rdd_a, rdd_b;
    logic          rdv_a, rdv_b, rdp_a, rdp_b, rdy_a, rdy_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ram_sync_dp_be #(.AWIDTH(AW), .DWIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdd_a), .rd_valid_o(rdv_a), .rd_perr_o(rdp_a),
        .ready_o(rdy_a), .init_busy_o(busy_a)
    );

    ram_sync_dp_be #(.AWIDTH(AW), .DWIDTH(DW), .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rdd_b), .rd_valid_o(rdv_b), .rd_perr_o(rdp_b),
        .ready_o(rdy_b), .init_busy_o(busy_b)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    logic [NB-1:0] m_bad [DEPTH];
    int            m_clr;
    logic          ea_v, ea_p, eb_v, eb_p, pb_v, pb_p;
    logic [DW-1:0] ea_d, eb_d, pb_d;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = '0;
        end
        m_clr = 0;
        ea_v = 1'b0; ea_p = 1'b0; ea_d = '0;
        eb_v = 1'b0; eb_p = 1'b0; eb_d = '0;
        pb_v = 1'b0; pb_p = 1'b0; pb_d = '0;
    endtask

    initial begin
        logic          run, acc_r, acc_w, hit, bad_old, bad_new;
        logic [DW-1:0] old_v, new_v;
        model_reset();
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                model_reset();
            end else begin
                run   = (m_clr == DEPTH);
                if (!run) m_clr++;
                acc_r = run && rd_en;
                acc_w = run && wr_en;
                hit   = acc_w && (wr_addr == rd_addr);
                old_v = m_mem[rd_addr];
                new_v = hit ? merge(old_v, wr_data, wr_be) : old_v;
                bad_old = |m_bad[rd_addr];
                bad_new = hit ? |(m_bad[rd_addr] & ~wr_be) : bad_old;
                if (acc_w) begin
                    m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
                    m_bad[wr_addr] = m_bad[wr_addr] & ~wr_be;
                end
                ea_v = acc_r;
                if (acc_r) begin ea_d = old_v; ea_p = bad_old; end
                eb_v = pb_v;
                if (pb_v) begin eb_d = pb_d; eb_p = pb_p; end
                pb_v = acc_r;
                if (acc_r) begin pb_d = new_v; pb_p = bad_new; end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clock);
            #2;
            check("a_valid", 32'(rdv_a), 32'(ea_v));
            check("a_data",  rdd_a, ea_d);
            check("a_perr",  32'(rdp_a), 32'(ea_v & ea_p));
            check("a_ready", 32'(rdy_a), 32'(m_clr == DEPTH));
            check("a_busy",  32'(busy_a), 32'(m_clr != DEPTH));
            check("b_valid", 32'(rdv_b), 32'(eb_v));
            check("b_data",  rdd_b, eb_d);
            check("b_perr",  32'(rdp_b), 32'(eb_v & eb_p));
            check("b_ready", 32'(rdy_b), 32'(m_clr == DEPTH));
            check("b_busy",  32'(busy_b), 32'(m_clr != DEPTH));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // One read (optionally with a same-cycle write); checks latency, data and parity flag of both DUTs.
    task automatic read_lit(input string name, input logic [AW-1:0] ra,
                            input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b, input logic exp_perr,
                            input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [NB-1:0] wbe);
        int            la, lb;
        logic [DW-1:0] da, db;
        logic          pa, pb;
        @(negedge clock);
        rd_en = 1'b1; rd_addr = ra;
        wr_en = w; wr_addr = wa; wr_data = wd; wr_be = wbe;
        la = 0; lb = 0; da = '0; db = '0; pa = 1'b0; pb = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock);
            #2;
            if (c == 1) begin rd_en = 1'b0; wr_en = 1'b0; end
            if (rdv_a && la == 0) begin la = c; da = rdd_a; pa = rdp_a; end
            if (rdv_b && lb == 0) begin lb = c; db = rdd_b; pb = rdp_b; end
        end
        check({name, "_lat_a"},  32'(la), 32'd1);
        check({name, "_lat_b"},  32'(lb), 32'd2);
        check({name, "_data_a"}, da, exp_a);
        check({name, "_data_b"}, db, exp_b);
        check({name, "_perr_a"}, 32'(pa), 32'(exp_perr));
        check({name, "_perr_b"}, 32'(pb), 32'(exp_perr));
    endtask

    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (!rdy_a && n < 20) begin
            @(posedge clock);
            #2;
            n++;
        end
        check(name, 32'(n), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa, fb, na, nb, lastb, n, nv;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(rdy_a), 32'd0);
        check("rst_busy",  32'(busy_b), 32'd1);
        check("rst_valid", 32'(rdv_b), 32'd0);
        check("rst_data",  rdd_a, 32'h0);
        reset_n = 1'b1;
        count_clear("clear_len");

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            rd_en = 1'b1; rd_addr = AW'(i);
        end
        @(negedge clock);
        rd_en = 1'b0;
        read_lit("zero7", 3'd7, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

        do_write(3'd5, 32'hDEADBEEF, 4'hF);
        do_write(3'd5, 32'h11223344, 4'b0101);
        read_lit("be_merge", 3'd5, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        do_write(3'd5, 32'hFFFFFFFF, 4'h0);
        read_lit("be_noop", 3'd5, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

        do_write(3'd2, 32'h12345678, 4'hF);
        read_lit("rdw_full", 3'd2, 32'h12345678, 32'hAAAA5555, 1'b0, 1'b1, 3'd2, 32'hAAAA5555, 4'hF);
        read_lit("rdw_after", 3'd2, 32'hAAAA5555, 32'hAAAA5555, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        read_lit("rdw_part", 3'd6, 32'h00000000, 32'h0000FFFF, 1'b0, 1'b1, 3'd6, 32'hFFFFFFFF, 4'b0011);
        read_lit("part_after", 3'd6, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        read_lit("rdw_diff", 3'd5, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 1'b1, 3'd4, 32'h5A5A5A5A, 4'hF);
        read_lit("diff_after", 3'd4, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 32'hC0DE0000 | 32'(i), 4'hF);
        fa = 0; fb = 0; na = 0; nb = 0; lastb = 0;
        for (int c = 1; c <= 12; c++) begin
            rd_en   = (c <= 8);
            rd_addr = AW'(c - 1);
            @(posedge clock);
            #2;
            if (rdv_a) begin
                if (na == 0) fa = c;
                check("stream_a_data", rdd_a, 32'hC0DE0000 | 32'(na));
                na++;
            end
            if (rdv_b) begin
                if (nb == 0) fb = c;
                check("stream_b_data", rdd_b, 32'hC0DE0000 | 32'(nb));
                nb++;
                lastb = c;
            end
        end
        rd_en = 1'b0;
        check("stream_a_first", 32'(fa), 32'd1);
        check("stream_a_count", 32'(na), 32'd8);
        check("stream_b_first", 32'(fb), 32'd2);
        check("stream_b_count", 32'(nb), 32'd8);
        check("stream_b_last",  32'(lastb), 32'd9);

        @(negedge clock);
        rd_en = 1'b1; rd_addr = 3'd5;
        @(negedge clock);
        rd_en = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        nv = 0;
        repeat (4) begin
            @(posedge clock);
            #2;
            if (rdv_a || rdv_b) nv++;
        end
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!rdy_a && n < 20) begin
            if (n == 5) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 3'd0;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(posedge clock);
            #2;
            n++;
            if (rdv_a || rdv_b) nv++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("clear_restart", 32'(n), 32'd8);
        check("no_valid_reset", 32'(nv), 32'd0);
        read_lit("clear_ignored", 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        read_lit("rezero5", 3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

`ifdef RAM_SYNC_DP_PARITY_EN
        do_write(3'd3, 32'h000000A5, 4'hF);
        @(negedge clock);
        dut_a.mem_q[3][DW] = ~dut_a.mem_q[3][DW];
        dut_b.mem_q[3][DW] = ~dut_b.mem_q[3][DW];
        m_bad[3][0] = 1'b1;
        read_lit("perr_flip", 3'd3, 32'h000000A5, 32'h000000A5, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        do_write(3'd3, 32'h00000001, 4'b0001);
        read_lit("perr_fixed", 3'd3, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
`endif

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
